ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6: RAM address width.
REQ-002 Parameter DATA_W, default 16: RAM data width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0 / req1  input  1  access request, port 0 (CPU core) / port 1 (loader/debug).
REQ-006 we0 / we1  input  1  1 = write, 0 = read; valid while reqN high.
REQ-007 addr0 / addr1  input  ADDR_W  RAM address per port.
REQ-008 wdata0 / wdata1  input  DATA_W  write data per port.
REQ-009 gnt0 / gnt1  output  1  one-cycle grant pulse; request latched.
REQ-010 done0 / done1  output  1  one-cycle completion pulse.
REQ-011 rdata  output  DATA_W  read data, valid while doneN high and held until the next read completes.
REQ-012 ram_read / ram_write  output  1  RAM strobes.
REQ-013 ram_addr  output  ADDR_W  RAM address.
REQ-014 ram_data_out  output  DATA_W  RAM write data.
REQ-015 ram_data_in  input  DATA_W  RAM read data, registered, valid one cycle after ram_read.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 FSM states SHALL be IDLE, ACCESS and RESP; IDLE->ACCESS on any sampled request, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-019 In IDLE with a request, the winner's we/addr/wdata SHALL be latched; in the next cycle (ACCESS) gntN=1 and ram_read or ram_write=1 for exactly one cycle, with ram_addr/ram_data_out equal to the latched values.
REQ-020 In RESP, for a read, ram_data_in SHALL be captured into rdata at the closing edge; doneN=1 in the following cycle (state IDLE). Writes pulse doneN identically with rdata unchanged.
REQ-021 Latency: request sampled at edge E -> gnt in cycle E+1 -> done in cycle E+3; max throughput one access per 3 cycles.
REQ-022 In the cycle done pulses, the FSM is IDLE and SHALL accept a new request.
REQ-023 Requester SHALL hold req/we/addr/wdata until gnt; dropping req before gnt withdraws the request with no side effects.
REQ-024 Requests arriving while busy SHALL be ignored until IDLE; a req still high in IDLE is a new transaction.
REQ-025 Default arbitration: fixed priority, port 0 wins when both requests are present.
REQ-026 At most one of gnt0/gnt1, one of done0/done1 and one of ram_read/ram_write SHALL be high in any cycle.
REQ-027 ram_addr/ram_data_out SHALL be 0 when both strobes are low.
REQ-028 Address values wrap naturally within ADDR_W; no range checking.

Reset
REQ-029 When reset=1 at an edge: state=IDLE; gnt0, gnt1, done0, done1, ram_read, ram_write, busy=0; ram_addr, ram_data_out, rdata=0; RR pointer=port 0.
REQ-030 Reset mid-transaction SHALL abort it with no done pulse; a write strobed in an ACCESS cycle that coincides with the reset edge is still committed by the RAM.
REQ-031 Reset SHALL take priority over any request sampled in the same cycle.

Configuration
REQ-032 Macro RAM_ARB_RR_EN: when defined, arbitration SHALL be round-robin: on simultaneous requests the port not granted most recently wins, and the pointer updates on every grant.
REQ-033 Without RAM_ARB_RR_EN, fixed priority per REQ-025 SHALL apply and no pointer register SHALL exist.

Verification
REQ-034 Port 1 write addr=0x05, wdata=0xBEEF at edge 0 -> gnt1 in cycle 1 with ram_write=1, ram_addr=0x05, ram_data_out=0xBEEF; done1 in cycle 3.
REQ-035 Port 0 read addr=0x05 after REQ-034 with RAM model -> ram_read in cycle 1; done0 in cycle 3 with rdata=0xBEEF.
REQ-036 req0 and req1 held high for 4 transactions -> fixed priority: gnt0 ×4, gnt1 never; with RAM_ARB_RR_EN: gnt0, gnt1, gnt0, gnt1.
REQ-037 reset=1 at the edge closing the ACCESS cycle of a port 0 read -> next cycle state IDLE, busy=0, no done0, rdata=0.
REQ-038 req1 pulsed for one cycle while busy, then dropped -> no gnt1, no RAM strobe for port 1.
REQ-039 req0 asserted in the cycle done1 pulses -> gnt0 in the next cycle; one-hot checks of REQ-026 hold throughout.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter in front of a single-port synchronous RAM.
//
// Each access takes three states: IDLE -> ACCESS -> RESP -> IDLE.
// Every output is driven from a register.
//   - In IDLE, a sampled request latches the winning port's command.
//   - ACCESS drives gntN and one RAM strobe.
//   - RESP captures the read data.
//   - doneN pulses in the following IDLE cycle.
//
// Optional build macro:
//   RAM_ARB_RR_EN  round-robin arbitration. On simultaneous requests the port
//                  not granted most recently wins. When the macro is
//                  undefined, arbitration is fixed priority with port 0 first
//                  and no pointer register is built.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req0/1, we0/1         per-port request and write enable (1 = write)
//   addr0/1, wdata0/1     per-port address and write data
//   gnt0/1                one-cycle grant pulse (ACCESS cycle)
//   done0/1               one-cycle completion pulse
//   rdata                 last read data, held until the next read completes
//   ram_read, ram_write   RAM strobes
//   ram_addr              RAM address
//   ram_data_out          RAM write data
//   ram_data_in           registered RAM read data (one cycle after ram_read)
//   busy                  high whenever the FSM is not IDLE
module ram_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_out,
  input  logic [DATA_W-1:0] ram_data_in,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

  state_t state;
  logic   cur_port;  // port owning the transaction in flight
  logic   cur_we;    // transaction in flight is a write
  logic   sel1;      // port 1 wins this cycle's arbitration
  logic   sel_we;

`ifdef RAM_ARB_RR_EN
  logic prio;  // port that wins a tie; points away from the last grant

  always_comb begin
    sel1 = req1 & (~req0 | prio);
  end
`else
  always_comb begin
    sel1 = req1 & ~req0;
  end
`endif

  always_comb begin
    sel_we = sel1 ? we1 : we0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StIdle;
      cur_port     <= 1'b0;
      cur_we       <= 1'b0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      ram_read     <= 1'b0;
      ram_write    <= 1'b0;
      ram_addr     <= '0;
      ram_data_out <= '0;
      rdata        <= '0;
      busy         <= 1'b0;
`ifdef RAM_ARB_RR_EN
      prio         <= 1'b0;
`endif
    end else begin
      // Pulses and strobes default low; the address/data bus is zero when idle.
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      ram_read     <= 1'b0;
      ram_write    <= 1'b0;
      ram_addr     <= '0;
      ram_data_out <= '0;
      case (state)
        StIdle: begin
          if (req0 || req1) begin
            state        <= StAccess;
            busy         <= 1'b1;
            cur_port     <= sel1;
            cur_we       <= sel_we;
            gnt0         <= ~sel1;
            gnt1         <= sel1;
            ram_read     <= ~sel_we;
            ram_write    <= sel_we;
            ram_addr     <= sel1 ? addr1 : addr0;
            ram_data_out <= sel1 ? wdata1 : wdata0;
`ifdef RAM_ARB_RR_EN
            prio         <= ~sel1;
`endif
          end
        end
        StAccess: begin
          state <= StResp;
        end
        StResp: begin
          // The RAM's registered read data is valid during this cycle.
          state <= StIdle;
          busy  <= 1'b0;
          if (!cur_we) begin
            rdata <= ram_data_in;
          end
          done0 <= ~cur_port;
          done1 <= cur_port;
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM.
// Stimulus changes 1 time unit after each rising edge.
// Outputs are checked at that same point, so they show the values registered
// at the edge just passed.
module tb_ram_arbiter;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, done0, done1;
  logic [DATA_W-1:0] rdata;
  logic              ram_read, ram_write;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_out;
  logic [DATA_W-1:0] ram_data_in;
  logic              busy;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0         (req0),
    .req1         (req1),
    .we0          (we0),
    .we1          (we1),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .done0        (done0),
    .done1        (done1),
    .rdata        (rdata),
    .ram_read     (ram_read),
    .ram_write    (ram_write),
    .ram_addr     (ram_addr),
    .ram_data_out (ram_data_out),
    .ram_data_in  (ram_data_in),
    .busy         (busy)
  );

  // Synchronous RAM: write on the strobe edge, read data registered.
  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
    ram_data_in = '0;
  end
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_data_out;
    if (ram_read) ram_data_in <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // At most one grant, done and strobe in any cycle; the bus is zero when idle.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("onehot_gnt", 32'(gnt0 & gnt1), 32'd0);
      check("onehot_done", 32'(done0 & done1), 32'd0);
      check("onehot_strb", 32'(ram_read & ram_write), 32'd0);
      if (!ram_read && !ram_write) begin
        check("idle_bus", {ram_addr, ram_data_out}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    #1;
    do_reset();

    // Reset state.
    check("rst_outs", {gnt0, gnt1, done0, done1, ram_read, ram_write, busy}, 32'd0);
    check("rst_bus", {ram_addr, ram_data_out}, 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);

    // Port 1 writes 0xBEEF to 0x05.
    req1 = 1; we1 = 1; addr1 = 6'h05; wdata1 = 16'hBEEF;
    step();  // cycle 1
    check("wr_gnt1", {gnt0, gnt1, ram_read, ram_write, busy}, 32'b01011);
    check("wr_addr", 32'(ram_addr), 32'h05);
    check("wr_data", 32'(ram_data_out), 32'hBEEF);
    req1 = 0;
    step();  // cycle 2
    check("wr_c2", {gnt1, ram_write, done1, busy}, 32'b0001);
    step();  // cycle 3
    check("wr_done1", {done0, done1, busy}, 32'b010);
    check("wr_rdata", 32'(rdata), 32'd0);

    // Port 0 reads 0x05 back.
    req0 = 1; we0 = 0; addr0 = 6'h05;
    step();
    check("rd_gnt0", {gnt0, gnt1, ram_read, ram_write}, 32'b1010);
    check("rd_addr", 32'(ram_addr), 32'h05);
    req0 = 0;
    step();
    check("rd_c2", {done0, busy}, 32'b01);
    step();
    check("rd_done0", {done0, done1, busy}, 32'b100);
    check("rd_rdata", 32'(rdata), 32'hBEEF);
    step();
    check("rd_hold", {32'(rdata)} | {31'd0, done0}, 32'hBEEF);

    // Both ports held high for four transactions.
    do_reset();
    req0 = 1; we0 = 0; addr0 = 6'h05;
    req1 = 1; we1 = 0; addr1 = 6'h05;
    for (int t = 0; t < 4; t++) begin
      logic exp1;
`ifdef RAM_ARB_RR_EN
      exp1 = (t % 2) == 1;
`else
      exp1 = 1'b0;
`endif
      step();
      check($sformatf("arb_gnt_%0d", t), {gnt0, gnt1}, {30'd0, ~exp1, exp1});
      if (t == 3) begin
        req0 = 0;
        req1 = 0;
      end
      step();
      step();
      check($sformatf("arb_done_%0d", t), {done0, done1}, {30'd0, ~exp1, exp1});
    end
    check("arb_rdata", 32'(rdata), 32'hBEEF);

    // Reset at the edge closing a port 0 read's ACCESS cycle.
    step();
    req0 = 1; we0 = 0; addr0 = 6'h05;
    step();
    check("rr_gnt0", {gnt0, ram_read}, 32'b11);
    req0 = 0;
    reset = 1;
    step();
    reset = 0;
    check("rst_mid_busy", {busy, done0, ram_read}, 32'd0);
    check("rst_mid_rdata", 32'(rdata), 32'd0);
    step();
    check("rst_mid_nodone", {done0, done1, busy}, 32'd0);
    step();
    check("rst_mid_nodone2", {done0, done1, busy}, 32'd0);

    // req1 pulsed for one cycle while busy with a port 0 write.
    req0 = 1; we0 = 1; addr0 = 6'h07; wdata0 = 16'h1234;
    step();
    check("busy_gnt0", {gnt0, ram_write}, 32'b11);
    req0 = 0;
    req1 = 1; we1 = 1; addr1 = 6'h09; wdata1 = 16'h5555;
    step();
    req1 = 0;
    check("busy_c2", {gnt1, ram_write, ram_read}, 32'd0);
    step();
    check("busy_done0", {done0, gnt1}, 32'b10);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("busy_idle_%0d", i), {gnt1, ram_write, ram_read, busy}, 32'd0);
    end
    check("busy_mem9", 32'(mem[9]), 32'd0);
    check("busy_mem7", 32'(mem[7]), 32'h1234);

    // req0 raised in the cycle done1 pulses.
    req1 = 1; we1 = 1; addr1 = 6'h03; wdata1 = 16'hA5A5;
    step();
    req1 = 0;
    step();
    step();
    check("b2b_done1", {done1, busy}, 32'b10);
    req0 = 1; we0 = 0; addr0 = 6'h03;
    step();
    check("b2b_gnt0", {gnt0, gnt1, ram_read}, 32'b101);
    check("b2b_addr", 32'(ram_addr), 32'h03);
    req0 = 0;
    step();
    step();
    check("b2b_done0", {done0, done1}, 32'b10);
    check("b2b_rdata", 32'(rdata), 32'hA5A5);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
